// File: rtl/core_pkg.sv
// Shared core definitions: widths, ALU opcodes and the ID/EX register bundle.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package core_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  // ALU operation codes; 10..16 are branch/jump compares resolved downstream
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_XOR  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_BEQ  = 5'd10;
  localparam logic [4:0] ALU_BNE  = 5'd11;
  localparam logic [4:0] ALU_BLT  = 5'd12;
  localparam logic [4:0] ALU_BGE  = 5'd13;
  localparam logic [4:0] ALU_BLTU = 5'd14;
  localparam logic [4:0] ALU_BGEU = 5'd15;
  localparam logic [4:0] ALU_JUMP = 5'd16;

  // Everything the EX stage needs from decode, held in one register
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rd_addr;
    logic [4:0]      op_select;
    logic            use_pc;
    logic            use_imm;
    logic            reg_write;
    logic            is_load;
  } id_ex_t;

  // A bubble carries no side effects: invalid, no write, no load, rd=x0, ADD
  function automatic id_ex_t bubble();
    id_ex_t b;
    b           = '0;
    b.op_select = ALU_ADD;
    return b;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forward selector: MEM result, else WB result, else registered data.
// Latency: purely combinational.
// Backpressure: none; x0 is never forwarded.
module fwd_mux
  import core_pkg::*;
(
  input  logic [RA_W-1:0] src_addr,
  input  logic [XLEN-1:0] reg_data,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] fwd_data
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write & (mem_rd_addr != '0) & (mem_rd_addr == src_addr);
  assign wb_hit  = wb_reg_write  & (wb_rd_addr  != '0) & (wb_rd_addr  == src_addr);

  // Younger producer (MEM) takes priority over the older one (WB)
  always_comb begin
    fwd_data = reg_data;
    if (mem_hit) begin
      fwd_data = mem_result;
    end else if (wb_hit) begin
      fwd_data = wb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB capture bypass, MEM/WB operand forwarding and load-use bubble.
// Latency: 1 cycle ID->EX; forwarding is combinational on the registered operands.
// Backpressure: id_ready drops on flush, downstream stall or load-use hazard; EX holds while ex_ready=0.
module id_ex_stage #(
  parameter int XLEN = core_pkg::XLEN,
  parameter int RA_W = core_pkg::RA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic [4:0]      id_op_select,
  input  logic            id_use_pc,
  input  logic            id_use_imm,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [4:0]      alu_op_select,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_is_load
);

  import core_pkg::*;

  id_ex_t          ex_q;
  id_ex_t          cap;
  logic            hazard;
  logic            wb_hit1;
  logic            wb_hit2;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Load result is not available until after MEM; rs2 is checked even for immediates
  assign hazard = ex_q.valid & ex_q.is_load & (ex_q.rd_addr != '0) & id_valid &
                  ((id_rs1_addr == ex_q.rd_addr) | (id_rs2_addr == ex_q.rd_addr));

  assign id_ready = ~flush & ex_ready & ~hazard;

  // The register file is written at the same edge it is read, so take WB data directly
  assign wb_hit1 = wb_reg_write & (wb_rd_addr != '0) & (wb_rd_addr == id_rs1_addr);
  assign wb_hit2 = wb_reg_write & (wb_rd_addr != '0) & (wb_rd_addr == id_rs2_addr);

  // Assemble the bundle captured from ID, with the WB bypass applied to the read data
  always_comb begin
    cap           = '0;
    cap.valid     = 1'b1;
    cap.pc        = id_pc;
    cap.rs1_addr  = id_rs1_addr;
    cap.rs2_addr  = id_rs2_addr;
    cap.rs1_data  = wb_hit1 ? wb_result : id_rs1_data;
    cap.rs2_data  = wb_hit2 ? wb_result : id_rs2_data;
    cap.imm       = id_imm;
    cap.rd_addr   = id_rd_addr;
    cap.op_select = id_op_select;
    cap.use_pc    = id_use_pc;
    cap.use_imm   = id_use_imm;
    cap.reg_write = id_reg_write;
    cap.is_load   = id_is_load;
  end

  // Update priority: reset, flush, downstream hold, load-use bubble, capture, idle bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q <= bubble();
    end else if (!ex_ready) begin
      ex_q <= ex_q;
    end else if (hazard) begin
      ex_q <= bubble();
    end else if (id_valid) begin
      ex_q <= cap;
    end else begin
      ex_q <= bubble();
    end
  end

  fwd_mux u_fwd_rs1 (
    .src_addr      (ex_q.rs1_addr),
    .reg_data      (ex_q.rs1_data),
    .mem_reg_write (mem_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .fwd_data      (fwd_rs1)
  );

  fwd_mux u_fwd_rs2 (
    .src_addr      (ex_q.rs2_addr),
    .reg_data      (ex_q.rs2_data),
    .mem_reg_write (mem_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .fwd_data      (fwd_rs2)
  );

  assign ex_valid      = ex_q.valid;
  assign alu_in1       = ex_q.use_pc  ? ex_q.pc  : fwd_rs1;
  assign alu_in2       = ex_q.use_imm ? ex_q.imm : fwd_rs2;
  assign alu_op_select = ex_q.op_select;
  assign ex_store_data = fwd_rs2;
  assign ex_pc         = ex_q.pc;
  assign ex_rd_addr    = ex_q.rd_addr;
  assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
  assign ex_is_load    = ex_q.valid & ex_q.is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios followed by randomized traffic.
// Expected responses come from a per-instruction reference model and are queued per cycle.
// A negedge monitor pops and compares against the DUT outputs.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rd_addr;
  logic [4:0]  id_op_select;
  logic        id_use_pc, id_use_imm, id_reg_write, id_is_load;
  logic        flush, ex_ready;
  logic        mem_reg_write;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_result;
  logic        ex_valid;
  logic [31:0] alu_in1, alu_in2, ex_store_data, ex_pc;
  logic [4:0]  alu_op_select, ex_rd_addr;
  logic        ex_reg_write, ex_is_load;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd_addr(id_rd_addr), .id_op_select(id_op_select),
    .id_use_pc(id_use_pc), .id_use_imm(id_use_imm),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .flush(flush), .ex_ready(ex_ready),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .ex_valid(ex_valid), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_op_select(alu_op_select), .ex_store_data(ex_store_data),
    .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load)
  );

  // Reference model: the instruction currently sitting in EX, if any
  typedef struct {
    bit          valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd, op;
    bit          use_pc, use_imm, rw, ld;
  } instr_t;

  typedef struct {
    bit          full;
    bit          valid, idr, rw, ld;
    logic [31:0] in1, in2, store, pc;
    logic [4:0]  op, rd;
  } exp_t;

  instr_t m_ex;
  bit     m_just_rst;
  bit     last_idr;
  exp_t   sb[$];
  int     tests_run = 0;
  int     tests_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // The value a register reads as in EX: newest in-flight producer wins, x0 is constant
  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] file_val);
    if (a == 5'd0) return file_val;
    if (mem_reg_write && mem_rd_addr == a) return mem_result;
    if (wb_reg_write && wb_rd_addr == a) return wb_result;
    return file_val;
  endfunction

  function automatic bit load_use();
    return m_ex.valid && m_ex.ld && m_ex.rd != 0 && id_valid &&
           (id_rs1_addr == m_ex.rd || id_rs2_addr == m_ex.rd);
  endfunction

  task automatic model_edge();
    instr_t nxt;
    bit     hz;
    hz  = load_use();
    nxt = m_ex;
    m_just_rst = 1'b0;
    if (rst) begin
      nxt = '{default: 0};
      m_just_rst = 1'b1;
    end else if (flush || (ex_ready && (hz || !id_valid))) begin
      nxt.valid = 0; nxt.op = 0; nxt.rw = 0; nxt.ld = 0; nxt.rd = 0;
    end else if (ex_ready) begin
      nxt.valid = 1; nxt.pc = id_pc; nxt.imm = id_imm;
      nxt.rs1a = id_rs1_addr; nxt.rs2a = id_rs2_addr;
      nxt.rs1d = (wb_reg_write && wb_rd_addr != 0 && wb_rd_addr == id_rs1_addr) ? wb_result : id_rs1_data;
      nxt.rs2d = (wb_reg_write && wb_rd_addr != 0 && wb_rd_addr == id_rs2_addr) ? wb_result : id_rs2_data;
      nxt.rd = id_rd_addr; nxt.op = id_op_select;
      nxt.use_pc = id_use_pc; nxt.use_imm = id_use_imm;
      nxt.rw = id_reg_write; nxt.ld = id_is_load;
    end
    m_ex = nxt;
  endtask

  task automatic push_exp();
    exp_t        e;
    logic [31:0] r1, r2;
    r1 = operand(m_ex.rs1a, m_ex.rs1d);
    r2 = operand(m_ex.rs2a, m_ex.rs2d);
    e.full  = m_ex.valid || m_just_rst;
    e.valid = m_ex.valid;
    e.idr   = !flush && ex_ready && !load_use();
    e.in1   = m_ex.use_pc  ? m_ex.pc  : r1;
    e.in2   = m_ex.use_imm ? m_ex.imm : r2;
    e.store = r2;
    e.pc    = m_ex.pc;
    e.op    = m_ex.op;
    e.rd    = m_ex.rd;
    e.rw    = m_ex.valid && m_ex.rw;
    e.ld    = m_ex.valid && m_ex.ld;
    last_idr = e.idr;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc();
    push_exp();
    tick();
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [4:0] rd, input logic [4:0] op,
                          input bit upc, input bit uimm, input bit rw, input bit ld);
    id_valid = 1; id_pc = pc; id_rs1_addr = a1; id_rs2_addr = a2;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_rd_addr = rd;
    id_op_select = op; id_use_pc = upc; id_use_imm = uimm;
    id_reg_write = rw; id_is_load = ld;
  endtask

  task automatic clear_fwd();
    mem_reg_write = 0; mem_rd_addr = 0; mem_result = 0;
    wb_reg_write = 0;  wb_rd_addr = 0;  wb_result = 0;
  endtask

  // Monitor: compare whatever the DUT presents against the oldest queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
      chk("id_ready", {31'd0, id_ready}, {31'd0, e.idr});
      chk("alu_op_select", {27'd0, alu_op_select}, {27'd0, e.op});
      chk("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, e.rd});
      chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
      chk("ex_is_load", {31'd0, ex_is_load}, {31'd0, e.ld});
      if (e.full) begin
        chk("alu_in1", alu_in1, e.in1);
        chk("alu_in2", alu_in2, e.in2);
        chk("ex_store_data", ex_store_data, e.store);
        chk("ex_pc", ex_pc, e.pc);
      end
    end
  end

  initial begin
    m_ex = '{default: 0};
    m_just_rst = 0;
    last_idr = 0;
    rst = 1; flush = 0; ex_ready = 1;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    id_valid = 0;
    clear_fwd();
    tick();
    cyc();                                   // reset state
    rst = 0;

    // Plain capture: 5 + 7
    drive_id(32'h100, 1, 2, 5, 7, 0, 3, 5'd0, 0, 0, 1, 0);
    cyc();
    id_valid = 0;
    cyc();

    // MEM beats WB; rd=x0 sources are ignored; WB alone forwards
    drive_id(32'h104, 3, 6, 32'h11, 32'h22, 32'h40, 7, 5'd1, 0, 1, 1, 0);
    cyc();
    id_valid = 0; ex_ready = 0;
    mem_reg_write = 1; mem_rd_addr = 3; mem_result = 32'hAA;
    wb_reg_write = 1;  wb_rd_addr = 3;  wb_result = 32'hBB;
    cyc();
    mem_rd_addr = 0; wb_rd_addr = 0;
    cyc();
    mem_reg_write = 0; wb_rd_addr = 3;
    cyc();
    ex_ready = 1;
    clear_fwd();

    // Load-use: load x4, then a consumer of x4 waits one bubble
    drive_id(32'h200, 1, 2, 32'h10, 32'h20, 32'h8, 4, 5'd0, 0, 1, 1, 1);
    cyc();
    drive_id(32'h204, 4, 5, 32'h33, 32'h44, 0, 6, 5'd2, 0, 0, 1, 0);
    cyc();
    cyc();
    id_valid = 0;
    mem_reg_write = 1; mem_rd_addr = 4; mem_result = 32'h1234;
    cyc();
    clear_fwd();

    // Downstream stall for three cycles, then release captures the waiting instruction
    drive_id(32'h300, 1, 2, 1, 2, 0, 8, 5'd10, 0, 0, 0, 0);
    cyc();
    ex_ready = 0;
    drive_id(32'h304, 9, 10, 32'h99, 32'hA0, 32'h4, 11, 5'd16, 1, 1, 1, 0);
    repeat (3) cyc();
    ex_ready = 1;
    cyc();
    id_valid = 0;
    cyc();

    // Flush during a stall drops both EX and the ID instruction
    drive_id(32'h400, 1, 2, 3, 4, 0, 12, 5'd4, 0, 0, 1, 0);
    cyc();
    ex_ready = 0; flush = 1;
    drive_id(32'h404, 1, 2, 5, 6, 0, 13, 5'd3, 0, 0, 1, 0);
    cyc();
    flush = 0; ex_ready = 1; id_valid = 0;
    cyc();

    // Reset while EX holds a valid instruction
    drive_id(32'h500, 1, 2, 7, 8, 32'hFF, 14, 5'd15, 1, 1, 1, 1);
    cyc();
    rst = 1; id_valid = 0;
    cyc();
    rst = 0;
    cyc();

    // Randomized traffic; ID holds a stalled instruction until it is taken
    for (int i = 0; i < 3000; i++) begin
      bit hold;
      hold = id_valid && !last_idr && !flush && !rst;
      rst      = ($urandom_range(0, 199) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      ex_ready = ($urandom_range(0, 99) < 85);
      if (!hold) begin
        drive_id($urandom(), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom(), $urandom(), $urandom(), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 16)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0));
        id_valid = ($urandom_range(0, 3) != 0);
      end
      mem_reg_write = bit'($urandom_range(0, 1));
      mem_rd_addr   = 5'($urandom_range(0, 7));
      mem_result    = $urandom();
      wb_reg_write  = bit'($urandom_range(0, 1));
      wb_rd_addr    = 5'($urandom_range(0, 7));
      wb_result     = $urandom();
      cyc();
    end

    id_valid = 0; rst = 0; flush = 0; ex_ready = 1;
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
